hls_deadlock_reporter: RTL and testbench
========================================

HLS_DEADLOCK_REPORTER -- requirements
Module: hls_deadlock_reporter

Interface
REQ-001 Parameter NUM_SRC, default 3: number of deadlock-monitor block inputs.
REQ-002 Parameter PERSIST_CYCLES, default 16: consecutive blocked cycles needed to declare deadlock; legal range 1..65535.
REQ-003 Parameter TS_WIDTH, default 32: width of the free-running cycle counter and timestamp.
REQ-004 clock  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 block_sigs  input  NUM_SRC  registered block outputs of per-instance deadlock monitors; bit i high = monitor i reports block.
REQ-007 clear  input  1  single-cycle pulse; returns block to watching.
REQ-008 report_valid  output  1  deadlock report available.
REQ-009 report_ready  input  1  sink accepts report.
REQ-010 report_src_mask  output  NUM_SRC  block_sigs snapshot at declaration.
REQ-011 report_cycle  output  TS_WIDTH  cycle-counter value on first cycle of persistence window.
REQ-012 deadlock  output  1  sticky flag, high from declaration until clear or reset.
REQ-013 busy  output  1  high in ARMED and REPORT states.

Function
REQ-014 any_block = OR-reduce of block_sigs, evaluated every cycle.
REQ-015 States: IDLE, ARMED, REPORT, HALTED; one state register.
REQ-016 Cycle counter: increments by 1 every non-reset cycle; wraps modulo 2^TS_WIDTH; unaffected by clear.
REQ-017 IDLE: any_block=1 -> ARMED, persist counter := 1, start timestamp := current cycle counter; else stay.
REQ-018 ARMED: any_block=0 -> IDLE, persist counter := 0, no report.
REQ-019 ARMED: any_block=1 and persist counter = PERSIST_CYCLES-1 -> REPORT, latch report_src_mask := block_sigs, report_cycle := start timestamp, deadlock := 1.
REQ-020 ARMED: any_block=1 otherwise -> persist counter increments; stays ARMED.
REQ-021 PERSIST_CYCLES=1: IDLE with any_block=1 goes straight to REPORT; start timestamp = that cycle's counter.
REQ-022 Persistence window needs any_block, not the same bit; a source handoff keeps counting.
REQ-023 REPORT: report_valid=1; report_src_mask, report_cycle stable until handshake.
REQ-024 Handshake = report_valid & report_ready on a rising edge; next state HALTED, report_valid := 0.
REQ-025 report_ready ignored outside REPORT; ready high before valid gives handshake on first REPORT cycle.
REQ-026 HALTED: ignores block_sigs; deadlock stays 1; report_src_mask, report_cycle hold.
REQ-027 clear=1 in any state (priority over all transitions and a same-cycle handshake) -> IDLE; persist counter, deadlock, report_valid, report_src_mask, report_cycle := 0.
REQ-028 Clear with any_block=1 in the same cycle: next state IDLE; new window starts earliest next cycle.
REQ-029 Persist counter width = clog2(PERSIST_CYCLES+1); never exceeds PERSIST_CYCLES-1.
REQ-030 busy = (state==ARMED) | (state==REPORT), combinational from state.
REQ-031 One report per deadlock episode; no new report until clear.

Reset
REQ-032 reset=1 on a rising edge: state := IDLE; cycle counter, persist counter, deadlock, report_valid, report_src_mask, report_cycle := 0.
REQ-033 Reset mid-operation (ARMED/REPORT/HALTED) aborts immediately; pending report discarded, no handshake.
REQ-034 First post-reset cycle: cycle counter = 0; block_sigs sampled normally.

Verification
REQ-035 PERSIST_CYCLES=4, block_sigs=3'b010 from cycle 10, held -> report_valid rises after edge at cycle 13, mask=3'b010, report_cycle=10, deadlock=1.
REQ-036 block_sigs=3'b001 for 3 cycles then 0 (PERSIST_CYCLES=4) -> no report, deadlock=0, back to IDLE, busy low next cycle.
REQ-037 Source handoff 3'b001 x2 then 3'b100 x2 (PERSIST_CYCLES=4) -> report issued, mask=3'b100.
REQ-038 report_ready low 5 cycles after report_valid -> valid and payload stable; ready high 1 cycle -> HALTED, valid 0, deadlock stays 1.
REQ-039 clear and report_ready same cycle in REPORT -> IDLE, deadlock=0, mask=0, report_cycle=0.
REQ-040 reset pulse while ARMED (persist=2) -> all outputs 0, cycle counter restarts at 0, later block needs full PERSIST_CYCLES again.

Source files
------------

// File: rtl/hls_deadlock_reporter.sv
// Collects block flags from per-instance deadlock monitors, declares a deadlock
// once any of them stays blocked for PERSIST_CYCLES cycles, and issues one report.
module hls_deadlock_reporter #(
  parameter int NUM_SRC        = 3,
  parameter int PERSIST_CYCLES = 16,
  parameter int TS_WIDTH       = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_SRC-1:0]  block_sigs,
  input  logic                clear,
  output logic                report_valid,
  input  logic                report_ready,
  output logic [NUM_SRC-1:0]  report_src_mask,
  output logic [TS_WIDTH-1:0] report_cycle,
  output logic                deadlock,
  output logic                busy
);

  // state   | meaning
  // IDLE    | watching for any block flag
  // ARMED   | persistence window open, counting blocked cycles
  // REPORT  | deadlock declared, report offered to sink
  // HALTED  | report accepted, waiting for clear
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ARMED  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam int              PW           = $clog2(PERSIST_CYCLES + 1);
  localparam logic [PW-1:0]   PERSIST_LAST = PW'(PERSIST_CYCLES - 1);

  logic [1:0]          state;
  logic [PW-1:0]       persist_cnt;
  logic [TS_WIDTH-1:0] cycle_cnt;
  logic [TS_WIDTH-1:0] start_ts;
  logic                any_block;

  assign any_block = |block_sigs;
  assign busy      = (state == ARMED) | (state == REPORT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      persist_cnt     <= '0;
      cycle_cnt       <= '0;
      start_ts        <= '0;
      deadlock        <= 1'b0;
      report_valid    <= 1'b0;
      report_src_mask <= '0;
      report_cycle    <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + TS_WIDTH'(1);
      if (clear) begin
        state           <= IDLE;
        persist_cnt     <= '0;
        deadlock        <= 1'b0;
        report_valid    <= 1'b0;
        report_src_mask <= '0;
        report_cycle    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (any_block) begin
              // A one-cycle window declares on the very first blocked cycle.
              if (PERSIST_CYCLES == 1) begin
                state           <= REPORT;
                report_src_mask <= block_sigs;
                report_cycle    <= cycle_cnt;
                deadlock        <= 1'b1;
                report_valid    <= 1'b1;
              end else begin
                state       <= ARMED;
                persist_cnt <= PW'(1);
                start_ts    <= cycle_cnt;
              end
            end
          end
          ARMED: begin
            if (!any_block) begin
              state       <= IDLE;
              persist_cnt <= '0;
            end else if (persist_cnt == PERSIST_LAST) begin
              state           <= REPORT;
              persist_cnt     <= '0;
              report_src_mask <= block_sigs;
              report_cycle    <= start_ts;
              deadlock        <= 1'b1;
              report_valid    <= 1'b1;
            end else begin
              persist_cnt <= persist_cnt + PW'(1);
            end
          end
          REPORT: begin
            if (report_ready) begin
              state        <= HALTED;
              report_valid <= 1'b0;
            end
          end
          HALTED: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hls_deadlock_reporter.sv
// Directed bench for hls_deadlock_reporter (PERSIST_CYCLES=4); accepted reports
// are matched against a queue of expected reports by an independent monitor.
module tb_hls_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  block_sigs = 3'b000;
  logic        clear = 1'b0;
  logic        report_ready = 1'b0;
  logic        report_valid;
  logic [2:0]  report_src_mask;
  logic [31:0] report_cycle;
  logic        deadlock;
  logic        busy;

  typedef struct {
    logic [2:0]  mask;
    logic [31:0] cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc_m = '0;

  hls_deadlock_reporter #(
    .NUM_SRC(3),
    .PERSIST_CYCLES(4),
    .TS_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .block_sigs(block_sigs),
    .clear(clear),
    .report_valid(report_valid),
    .report_ready(report_ready),
    .report_src_mask(report_src_mask),
    .report_cycle(report_cycle),
    .deadlock(deadlock),
    .busy(busy)
  );

  always #5 clock = ~clock;

  // Reference cycle counter: value the DUT counter should hold in the current cycle.
  always @(posedge clock) begin
    if (reset) cyc_m <= '0;
    else       cyc_m <= cyc_m + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_until_cycle(input logic [31:0] n);
    int budget = 200;
    while (cyc_m != n && budget > 0) begin
      step();
      budget--;
    end
    if (cyc_m != n) chk("wait_cycle_timeout", {32'd0, cyc_m}, {32'd0, n});
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  // Monitor: every accepted handshake must match the oldest expected report.
  always @(negedge clock) begin
    if (!reset && !clear && report_valid && report_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_report", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_mask", {61'd0, report_src_mask}, {61'd0, e.mask});
        chk("sb_cycle", {32'd0, report_cycle}, {32'd0, e.cyc});
        chk("sb_deadlock", {63'd0, deadlock}, 64'd1);
      end
    end
  end

  initial begin
    step(2);
    reset = 1'b0;
    chk("rst_valid", {63'd0, report_valid}, 64'd0);
    chk("rst_deadlock", {63'd0, deadlock}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_mask", {61'd0, report_src_mask}, 64'd0);
    chk("rst_cycle", {32'd0, report_cycle}, 64'd0);

    // Block from cycle 10 held: report after the edge at cycle 13.
    wait_until_cycle(32'd10);
    block_sigs = 3'b010;
    exp_q.push_back('{mask: 3'b010, cyc: 32'd10});
    step(3);
    chk("arm_busy", {63'd0, busy}, 64'd1);
    chk("arm_no_valid", {63'd0, report_valid}, 64'd0);
    chk("arm_no_deadlock", {63'd0, deadlock}, 64'd0);
    step();
    chk("rep_valid", {63'd0, report_valid}, 64'd1);
    chk("rep_deadlock", {63'd0, deadlock}, 64'd1);
    chk("rep_busy", {63'd0, busy}, 64'd1);

    // Backpressure: payload holds while ready is low, even as blocks change.
    for (int i = 0; i < 5; i++) begin
      block_sigs = (i % 2 == 0) ? 3'b101 : 3'b000;
      step();
      chk("bp_valid", {63'd0, report_valid}, 64'd1);
      chk("bp_mask", {61'd0, report_src_mask}, 64'd2);
      chk("bp_cycle", {32'd0, report_cycle}, 64'd10);
    end
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    chk("halt_valid", {63'd0, report_valid}, 64'd0);
    chk("halt_deadlock", {63'd0, deadlock}, 64'd1);
    chk("halt_busy", {63'd0, busy}, 64'd0);
    block_sigs = 3'b111;
    report_ready = 1'b1;
    step(3);
    report_ready = 1'b0;
    chk("halt_ignore_valid", {63'd0, report_valid}, 64'd0);
    chk("halt_hold_mask", {61'd0, report_src_mask}, 64'd2);
    chk("halt_hold_cycle", {32'd0, report_cycle}, 64'd10);
    block_sigs = 3'b000;
    pulse_clear();
    chk("clr_deadlock", {63'd0, deadlock}, 64'd0);
    chk("clr_mask", {61'd0, report_src_mask}, 64'd0);
    chk("clr_cycle", {32'd0, report_cycle}, 64'd0);
    chk("clr_busy", {63'd0, busy}, 64'd0);

    // Three blocked cycles then release: no report.
    block_sigs = 3'b001;
    step();
    chk("short_busy", {63'd0, busy}, 64'd1);
    step(2);
    block_sigs = 3'b000;
    step();
    chk("short_busy_low", {63'd0, busy}, 64'd0);
    chk("short_no_valid", {63'd0, report_valid}, 64'd0);
    chk("short_no_deadlock", {63'd0, deadlock}, 64'd0);
    step(2);
    chk("short_still_idle", {63'd0, report_valid}, 64'd0);

    // Source handoff keeps the window counting.
    exp_q.push_back('{mask: 3'b100, cyc: cyc_m});
    block_sigs = 3'b001;
    step(2);
    block_sigs = 3'b100;
    step(2);
    chk("hand_valid", {63'd0, report_valid}, 64'd1);
    chk("hand_mask", {61'd0, report_src_mask}, 64'd4);
    block_sigs = 3'b000;
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    chk("hand_halt_valid", {63'd0, report_valid}, 64'd0);
    pulse_clear();

    // Clear beats a same-cycle handshake; block held through clear rearms next cycle.
    block_sigs = 3'b010;
    step(4);
    chk("cr_valid", {63'd0, report_valid}, 64'd1);
    clear = 1'b1;
    report_ready = 1'b1;
    step();
    clear = 1'b0;
    report_ready = 1'b0;
    chk("cr_valid_low", {63'd0, report_valid}, 64'd0);
    chk("cr_deadlock", {63'd0, deadlock}, 64'd0);
    chk("cr_mask", {61'd0, report_src_mask}, 64'd0);
    chk("cr_cycle", {32'd0, report_cycle}, 64'd0);
    chk("cr_busy_idle", {63'd0, busy}, 64'd0);
    step();
    chk("cr_rearm_busy", {63'd0, busy}, 64'd1);
    block_sigs = 3'b000;
    step();
    chk("cr_idle_again", {63'd0, busy}, 64'd0);

    // Reset while ARMED with persist=2; counter restarts so next report stamps 0.
    block_sigs = 3'b001;
    step(2);
    chk("rst2_armed", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2_busy", {63'd0, busy}, 64'd0);
    chk("rst2_valid", {63'd0, report_valid}, 64'd0);
    chk("rst2_deadlock", {63'd0, deadlock}, 64'd0);
    block_sigs = 3'b100;
    exp_q.push_back('{mask: 3'b100, cyc: 32'd0});
    step(3);
    chk("rst2_no_early", {63'd0, report_valid}, 64'd0);
    step();
    chk("rst2_valid_full", {63'd0, report_valid}, 64'd1);
    report_ready = 1'b1;
    step();
    report_ready = 1'b0;
    block_sigs = 3'b000;
    pulse_clear();
    step(2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
